// File: rtl/handshake_arb_pkg.sv
// Shared helpers for the constant-token round-robin arbiter: index sizing and
// pointer wrap-around arithmetic.
package handshake_arb_pkg;

   // Width of a requester index, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
   endfunction

   // Next round-robin start position after granting idx among n requesters.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx >= n - 32'sd1) ? 32'sd0 : idx + 32'sd1;
   endfunction

endpackage

// File: rtl/handshake_rr_grant.sv
// Combinational round-robin priority encoder: the lowest set request at or
// after ptr wins, wrapping past the top via a doubled request vector.
module handshake_rr_grant
   import handshake_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [2*N_REQ-1:0] dbl_s;

   // Descending scan so the lowest unmasked position is the one left standing.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = {IDX_W{1'b0}};
      dbl_s     = {req, req};
      for (int j = 2*N_REQ - 1; j >= 0; j--) begin
         if (dbl_s[j] && (j >= int'(ptr))) begin
            gnt_valid = 1'b1;
            gnt_idx   = IDX_W'(j % N_REQ);
         end else begin
            gnt_valid = gnt_valid;
         end
      end
   end

endmodule

// File: rtl/handshake_const_rr_arbiter.sv
// Shares one constant-token source among N_REQ control channels: a round-robin
// grant picks one requester per transfer and a registered stage emits the constant.
module handshake_const_rr_arbiter
   import handshake_arb_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter int          N_REQ       = 4,
   parameter logic [31:0] CONST_VALUE = 32'h0000064E,
   parameter int          IDX_W       = idx_width(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      ins_valid,
   output logic [N_REQ-1:0]      ins_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic [IDX_W-1:0]      outs_index,
   output logic                  outs_valid,
   input  logic                  outs_ready
);

   localparam logic [DATA_WIDTH-1:0] CONST_D = DATA_WIDTH'(CONST_VALUE);

   logic [IDX_W-1:0]      ptr_r;
   logic [DATA_WIDTH-1:0] outs_r;
   logic [IDX_W-1:0]      outs_index_r;
   logic                  outs_valid_r;
   logic                  load_en_s;
   logic                  take_s;
   logic                  gnt_valid_s;
   logic [IDX_W-1:0]      gnt_idx_s;

   handshake_rr_grant #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_grant (
      .req       (ins_valid),
      .ptr       (ptr_r),
      .gnt_valid (gnt_valid_s),
      .gnt_idx   (gnt_idx_s)
   );

   // Gating with rst keeps every ready low while reset is asserted.
   assign load_en_s = rst && (!outs_valid_r || outs_ready);

   // One-hot accept for the granted requester when the output stage can load.
   always_comb begin
      ins_ready = {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         ins_ready[i] = load_en_s && gnt_valid_s && (gnt_idx_s == IDX_W'(i)) && ins_valid[i];
      end
   end

   assign take_s = |ins_ready;

   // Output register and round-robin pointer; pointer moves only on a real transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_r        <= {IDX_W{1'b0}};
         outs_r       <= {DATA_WIDTH{1'b0}};
         outs_index_r <= {IDX_W{1'b0}};
         outs_valid_r <= 1'b0;
      end else if (take_s) begin
         outs_r       <= CONST_D;
         outs_index_r <= gnt_idx_s;
         outs_valid_r <= 1'b1;
         ptr_r        <= IDX_W'(wrap_inc(int'(gnt_idx_s), N_REQ));
      end else if (outs_ready) begin
         outs_valid_r <= 1'b0;
      end else begin
         outs_valid_r <= outs_valid_r;
      end
   end

   assign outs       = outs_r;
   assign outs_index = outs_index_r;
   assign outs_valid = outs_valid_r;

endmodule

// File: tb/tb_handshake_const_rr_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected grant indices, a monitor
// pops them on each output handshake; a one-requester instance checks token counts.
module tb_handshake_const_rr_arbiter;

   localparam logic [31:0] K = 32'h0000064E;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ins_valid;
   logic [3:0]  ins_ready;
   logic [31:0] outs;
   logic [1:0]  outs_index;
   logic        outs_valid;
   logic        outs_ready;

   logic [0:0]  v1;
   logic [0:0]  r1;
   logic [31:0] outs1;
   logic [0:0]  idx1;
   logic        ov1;
   logic        or1;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int in1 = 0;
   int out1 = 0;
   logic exp_ov1;

   always #5 clk = ~clk;

   handshake_const_rr_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs       (outs),
      .outs_index (outs_index),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready)
   );

   handshake_const_rr_arbiter #(.N_REQ(1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (v1),
      .ins_ready  (r1),
      .outs       (outs1),
      .outs_index (idx1),
      .outs_valid (ov1),
      .outs_ready (or1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every output handshake must match the oldest expected token.
   always @(negedge clk) begin
      int e;
      if (rst === 1'b1 && outs_valid === 1'b1 && outs_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_token actual_index=%0d required=none", outs_index);
         end else begin
            e = exp_q.pop_front();
            chk("outs_index", outs_index, e);
            chk("outs", outs, K);
         end
      end
      if (rst === 1'b1 && ov1 === 1'b1 && or1 === 1'b1) begin
         out1++;
         chk("n1_index", idx1, 0);
         chk("n1_outs", outs1, K);
      end
   end

   // Drive one cycle, check ins_ready just after the falling edge, log the expected grant.
   task automatic cyc(input logic [3:0] iv, input logic ordy, input logic [3:0] exp_rdy);
      ins_valid  = iv;
      outs_ready = ordy;
      #5;
      chk("ins_ready", ins_ready, exp_rdy);
      for (int i = 0; i < 4; i++) begin
         if (exp_rdy[i]) exp_q.push_back(i);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; ins_valid = 4'hF; outs_ready = 1'b1; v1 = 1'b0; or1 = 1'b0;
      @(posedge clk); #1;
      #5;
      chk("rst_valid", outs_valid, 0);
      chk("rst_outs", outs, 0);
      chk("rst_index", outs_index, 0);
      chk("rst_ready", ins_ready, 0);
      @(posedge clk); #1;
      rst = 1'b1; ins_valid = 4'h0;
      @(posedge clk); #1;

      // First token from requester 0; ptr becomes 1.
      cyc(4'b0001, 1'b1, 4'b0001);
      // All valid: rotation starting at 1.
      cyc(4'b1111, 1'b1, 4'b0010);
      cyc(4'b1111, 1'b1, 4'b0100);
      cyc(4'b1111, 1'b1, 4'b1000);
      cyc(4'b1111, 1'b1, 4'b0001);
      cyc(4'b1111, 1'b1, 4'b0010);
      cyc(4'b1111, 1'b1, 4'b0100);
      cyc(4'b1111, 1'b1, 4'b1000);
      cyc(4'b1111, 1'b1, 4'b0001);
      // Sparse and wrap: grant 2 (ptr->3), then 0 by wrap, then 2.
      cyc(4'b0100, 1'b1, 4'b0100);
      cyc(4'b0101, 1'b1, 4'b0001);
      cyc(4'b0101, 1'b1, 4'b0100);
      cyc(4'b0000, 1'b1, 4'b0000);

      // Backpressure: capture requester 1, then hold for 5 cycles.
      cyc(4'b0010, 1'b0, 4'b0010);
      for (int i = 0; i < 5; i++) begin
         cyc(4'b0010, 1'b0, 4'b0000);
         chk("stall_valid", outs_valid, 1);
         chk("stall_index", outs_index, 1);
         chk("stall_outs", outs, K);
      end
      // Drain and reload in the same cycle.
      cyc(4'b0010, 1'b1, 4'b0010);
      cyc(4'b0000, 1'b1, 4'b0000);

      // Drop request: requester 2 valid only while stalled, then withdraws.
      cyc(4'b0001, 1'b1, 4'b0001);
      cyc(4'b0100, 1'b0, 4'b0000);
      cyc(4'b0000, 1'b0, 4'b0000);
      cyc(4'b0000, 1'b1, 4'b0000);
      cyc(4'b0000, 1'b1, 4'b0000);
      cyc(4'b1010, 1'b1, 4'b0010);
      cyc(4'b1000, 1'b1, 4'b1000);
      cyc(4'b0000, 1'b1, 4'b0000);

      // Mid-stream reset with a held token; ptr was 0, grant 0 moves it to 1.
      cyc(4'b1111, 1'b0, 4'b0001);
      chk("pre_rst_valid", outs_valid, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", outs_valid, 0);
      chk("mid_rst_outs", outs, 0);
      chk("mid_rst_index", outs_index, 0);
      chk("mid_rst_ready", ins_ready, 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      cyc(4'b1111, 1'b1, 4'b0001);
      cyc(4'b0000, 1'b1, 4'b0000);
      chk("queue_empty", exp_q.size(), 0);

      // Single-requester instance with random valid/ready.
      exp_ov1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         logic er;
         v1  = 1'($urandom_range(0, 1));
         or1 = 1'($urandom_range(0, 1));
         #5;
         er = v1[0] && (!exp_ov1 || or1);
         chk("n1_ready", r1, er);
         chk("n1_valid", ov1, exp_ov1);
         if (er) in1++;
         exp_ov1 = er ? 1'b1 : (or1 ? 1'b0 : exp_ov1);
         @(posedge clk); #1;
      end
      v1 = 1'b0; or1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("n1_count", out1, in1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/handshake_const_rr_arbiter.md
Name: handshake_const_rr_arbiter

Overview:
- Shares one constant-token source among N requesting control channels in Dynamatic-generated elastic circuits.
- Each requester presents a control token. The block grants exactly one requester per transfer using round-robin priority.
- It emits the constant value CONST_VALUE tagged with the winner's index through a registered output stage, one token per accepted request.
- It sits between the fork/branch control network and downstream consumers that need both the constant and its origin (e.g. a mux select).

Parameters:
- DATA_WIDTH, 32, width of outs.
- N_REQ, 4, number of requesting control channels (>=1).
- CONST_VALUE, 32'h0000064E, constant emitted with every token; truncated or zero-extended to DATA_WIDTH.
- IDX_W, max(1, clog2(N_REQ)), width of outs_index (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low: rst=0 resets immediately; release is synchronous to clk.
- ins_valid  in  N_REQ  per-requester control token valid.
- ins_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- outs  out  DATA_WIDTH  registered constant value.
- outs_index  out  IDX_W  registered index of the granted requester.
- outs_valid  out  1  output token valid (registered).
- outs_ready  in  1  downstream accept.

Behaviour:
- Reset (rst=0): outs_valid=0, outs=0, outs_index=0, rr pointer ptr=0, ins_ready=0. This applies asynchronously and mid-operation. Any held token is discarded and no transfer is reported.
- load_en = !outs_valid || outs_ready. The output register is a full-throughput pipeline stage.
- Grant selection:
  - grant = first i with ins_valid[i]=1, searching ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1 (modulo N_REQ).
  - grant is combinational from ins_valid and ptr.
- ins_ready[i] = load_en && (grant==i) && ins_valid[i]. All bits are 0 when no ins_valid is set or when load_en=0.
- Transfer on input i = ins_valid[i] && ins_ready[i]. On the same clk edge:
  - outs <= CONST_VALUE, outs_index <= i, outs_valid <= 1;
  - ptr <= (i==N_REQ-1) ? 0 : i+1 (wrap-around).
- Output drain without a new load (outs_valid && outs_ready, no input transfer): outs_valid <= 0. outs and outs_index hold their old values.
- Same-cycle drain and load: the register is reloaded and outs_valid stays 1. This gives a sustained throughput of 1 token/cycle.
- Stall (outs_valid && !outs_ready): outs, outs_index and ptr hold; all ins_ready=0.
- Latency: 1 cycle from input transfer to outs_valid.
- Combinational paths:
  - No combinational path from ins_valid to outs_valid.
  - The outs_ready -> ins_ready path is allowed; it is the only through-path.
- Fairness: with requester i continuously valid, it is granted within N_REQ transfers.
- The arbiter must not assume requesters hold valid until ready; grant is recomputed every cycle.
- N_REQ=1: grant is always 0, ptr stays 0, and the block is a plain one-stage constant buffer.
- Parameters are fixed at elaboration. No runtime configuration.

Decomposition:
- Shared package handshake_arb_pkg:
  - clog2-based index-width function;
  - a wrap-increment helper for ptr.
- One sub-module, handshake_rr_grant: purely combinational round-robin priority encoder.
  - Inputs: req[N_REQ], ptr[IDX_W].
  - Outputs: gnt_valid, gnt_idx[IDX_W].
  - Implemented as double-width masked priority search.
- The top level holds ptr, the output register and the handshake logic.

Test Plan:
- Reset: drive rst=0 mid-stream with outs_valid=1 -> outs_valid drops immediately, outs=0, ptr=0. After release, ins_valid=4'b0001 yields outs=32'h64E, outs_index=0 one cycle later.
- All valid: ins_valid=4'b1111, outs_ready=1 for 8 cycles -> outs_index sequence 0,1,2,3,0,1,2,3 with outs_valid high every cycle and one ins_ready bit per cycle.
- Sparse and wrap: ptr=3 after granting 2, then ins_valid=4'b0101 -> grant 0 (wrap), then 2. Requester 3 is never acked because it is never valid.
- Backpressure: outs_ready=0 with ins_valid=4'b0010 -> first token captured, then ins_ready=0 and outs/outs_index stable for 5 cycles. After outs_ready=1, the held token drains and the next token from requester 1 loads in the same cycle.
- Drop request: requester 2 deasserts valid while not granted -> it is never acked, no spurious token is issued, and ptr advances only on real transfers.
- N_REQ=1 instance: ins_valid toggling with random outs_ready -> token count out equals token count in, and outs_index is always 0.
